// File: rtl/alu_pkg.sv
// Shared definitions for the registered N-bit ALU: opcodes and FSM state type.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_core_comb.sv
// Combinational WIDTH-bit ALU for the single-cycle opcodes. Any opcode it does
// not implement (including MUL, which the top sequences itself) is flagged illegal
// with a zero result.
module alu_core_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic [3:0]       alu_op,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             illegal
);

    logic [WIDTH-1:0] and_bits;
    logic [WIDTH-1:0] or_bits;
    logic [WIDTH-1:0] nor_bits;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt;

    // Bitwise logic as a row of 1-bit slices
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign and_bits[gi] = a[gi] & b[gi];
            assign or_bits[gi]  = a[gi] | b[gi];
            assign nor_bits[gi] = ~(a[gi] | b[gi]);
        end
    endgenerate

    // SUB is a + ~b + 1, so its carry out of the top bit means "no borrow"
    assign add_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
    assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
    assign slt      = $signed(a) < $signed(b);

    // Opcode decode; carry and overflow are meaningful for ADD/SUB only
    always_comb begin
        result    = '0;
        carry_out = 1'b0;
        overflow  = 1'b0;
        illegal   = 1'b0;
        case (alu_op)
            OP_AND: result = and_bits;
            OP_OR:  result = or_bits;
            OP_NOR: result = nor_bits;
            OP_ADD: begin
                result    = add_full[WIDTH-1:0];
                carry_out = add_full[WIDTH];
                overflow  = add_ovf;
            end
            OP_SUB: begin
                result    = sub_full[WIDTH-1:0];
                carry_out = sub_full[WIDTH];
                overflow  = sub_ovf;
            end
            OP_SLT: result = {{(WIDTH-1){1'b0}}, slt};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq_nbit.sv
// Registered N-bit ALU with valid/ready handshake on both sides and status flags.
// Define ALU_MUL_EN to enable the multi-cycle unsigned shift-add multiply (opcode
// 1000, WIDTH cycles); without it that opcode is illegal and the block is purely
// single-cycle.
module alu_seq_nbit
    import alu_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             err
);

    logic [WIDTH-1:0] core_result;
    logic             core_carry;
    logic             core_ovf;
    logic             core_illegal;

    logic             out_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_reg;
    logic             overflow_reg;
    logic             zero_reg;
    logic             negative_reg;
    logic             err_reg;

    logic             accept;
    logic             busy;
    logic             start_mul;
    logic             mul_done;
    logic [WIDTH-1:0] mul_result;
    logic             mul_carry;

    alu_core_comb #(.WIDTH(WIDTH)) u_core (
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .alu_op    (alu_op),
        .result    (core_result),
        .carry_out (core_carry),
        .overflow  (core_ovf),
        .illegal   (core_illegal)
    );

    // A pending result may be taken and replaced in the same cycle
    assign in_ready = !busy && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;

`ifdef ALU_MUL_EN
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t               state_reg;
    logic [2*WIDTH-1:0]   prod_reg;
    logic [2*WIDTH-1:0]   mcand_reg;
    logic [2*WIDTH-1:0]   prod_next;
    logic [WIDTH-1:0]     mplier_reg;
    logic [CW-1:0]        cnt_reg;

    assign busy       = (state_reg == ST_MUL);
    assign start_mul  = accept && (alu_op == OP_MUL);
    assign mul_done   = busy && (cnt_reg == '0);
    assign prod_next  = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign mul_result = prod_next[WIDTH-1:0];
    assign mul_carry  = |prod_next[2*WIDTH-1:WIDTH];

    // Multiply FSM: one multiplier bit per cycle, WIDTH iterations after accept
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            prod_reg   <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_mul) begin
                        prod_reg   <= '0;
                        mcand_reg  <= {{WIDTH{1'b0}}, a};
                        mplier_reg <= b;
                        cnt_reg    <= CW'(WIDTH - 1);
                        state_reg  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    prod_reg   <= prod_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
`else
    assign busy       = 1'b0;
    assign start_mul  = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_result = '0;
    assign mul_carry  = 1'b0;
`endif

    // Output registers: load on single-cycle accept or multiply completion,
    // otherwise hold until the consumer takes the result
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            carry_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            zero_reg      <= 1'b0;
            negative_reg  <= 1'b0;
            err_reg       <= 1'b0;
        end else if (accept && !start_mul) begin
            out_valid_reg <= 1'b1;
            result_reg    <= core_result;
            carry_reg     <= core_carry;
            overflow_reg  <= core_ovf;
            zero_reg      <= (core_result == '0);
            negative_reg  <= core_result[WIDTH-1];
            err_reg       <= core_illegal;
        end else if (mul_done) begin
            out_valid_reg <= 1'b1;
            result_reg    <= mul_result;
            carry_reg     <= mul_carry;
            overflow_reg  <= 1'b0;
            zero_reg      <= (mul_result == '0);
            negative_reg  <= mul_result[WIDTH-1];
            err_reg       <= 1'b0;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign carry_out = carry_reg;
    assign overflow  = overflow_reg;
    assign zero      = zero_reg;
    assign negative  = negative_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Self-checking bench for alu_seq_nbit at WIDTH=6: directed scenarios followed by
// random operations, all compared against an arithmetic reference model.
module tb_alu_seq_nbit;

    localparam int W = 6;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic [3:0]   alu_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;
    logic         negative;
    logic         err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
        logic         e;
        int           lat;
    } exp_t;

    alu_seq_nbit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain integer arithmetic on the operand values
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] av,
                                   input logic [W-1:0] bv, input logic ci);
        exp_t e;
        int ua, ub, sa, sb, s;
        ua = int'(av);
        ub = int'(bv);
        sa = (ua >= 32) ? ua - 64 : ua;
        sb = (ub >= 32) ? ub - 64 : ub;
        e.r = '0; e.c = 1'b0; e.v = 1'b0; e.e = 1'b0; e.lat = 1;
        case (op)
            4'b0000: e.r = av & bv;
            4'b0001: e.r = av | bv;
            4'b1100: e.r = ~(av | bv);
            4'b0010: begin
                s   = ua + ub + int'(ci);
                e.r = s[W-1:0];
                e.c = (s >= 64);
                e.v = (sa + sb + int'(ci) > 31) || (sa + sb + int'(ci) < -32);
            end
            4'b0110: begin
                s   = ua - ub;
                e.r = s[W-1:0];
                e.c = (ua >= ub);
                e.v = (sa - sb > 31) || (sa - sb < -32);
            end
            4'b0111: e.r = (sa < sb) ? 6'd1 : 6'd0;
`ifdef ALU_MUL_EN
            4'b1000: begin
                s     = ua * ub;
                e.r   = s[W-1:0];
                e.c   = (s >= 64);
                e.lat = W;
            end
`endif
            default: e.e = 1'b1;
        endcase
        e.z = (e.r == '0);
        e.n = e.r[W-1];
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".result"},    32'(result),    32'(e.r));
        check({tag, ".carry_out"}, 32'(carry_out), 32'(e.c));
        check({tag, ".overflow"},  32'(overflow),  32'(e.v));
        check({tag, ".zero"},      32'(zero),      32'(e.z));
        check({tag, ".negative"},  32'(negative),  32'(e.n));
        check({tag, ".err"},       32'(err),       32'(e.e));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".result"},    32'(result),    32'd0);
        check({tag, ".flags"},     32'({carry_out, overflow, zero, negative, err}), 32'd0);
        check({tag, ".in_ready"},  32'(in_ready),  32'd1);
    endtask

    // One operation: accept, offer junk while busy/pending, check latency and
    // outputs, stall for 'hold' cycles, then take the result
    task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic ci, input int hold);
        exp_t e;
        int   lat;
        int   w;
        e = model(op, av, bv, ci);
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check({tag, ".in_ready_start"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; alu_op = op; a = av; b = bv; carry_in = ci; out_ready = 1'b0;
        @(posedge clk); #1;
        alu_op = 4'($urandom); a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin
            check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(e.lat));
        check_out(tag, e);
        for (int i = 0; i < hold; i++) begin
            check({tag, ".in_ready_stall"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            check_out({tag, ".stall"}, e);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check({tag, ".in_ready_take"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".out_valid_after_take"}, 32'(out_valid), 32'd0);
        $display("op %s alu_op=%b a=%0d b=%0d cin=%0d -> result=%0d c=%0b v=%0b z=%0b n=%0b err=%0b lat=%0d",
                 tag, op, av, bv, ci, e.r, e.c, e.v, e.z, e.n, e.e, lat);
    endtask

    logic [3:0]   sc_ops [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                                 4'b0111, 4'b1100, 4'b1111, 4'b0101};
    logic [3:0]   tp_op [13];
    logic [W-1:0] tp_a  [13];
    logic [W-1:0] tp_b  [13];
    logic         tp_c  [13];

    initial begin
        exp_t e;
        int   w;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; carry_in = 1'b0; alu_op = 4'b0000;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_idle("reset");
        @(posedge clk); #1;
        check_idle("reset_plus1");

        do_op("add_19_15", 4'b0010, 6'd19, 6'd15, 1'b0, 0);
        do_op("sub_5_7",   4'b0110, 6'd5,  6'd7,  1'b1, 0);
        do_op("sub_9_9",   4'b0110, 6'd9,  6'd9,  1'b0, 0);
        do_op("add_cin",   4'b0010, 6'd63, 6'd0,  1'b1, 0);
        do_op("mul_7_9",   4'b1000, 6'd7,  6'd9,  1'b0, 0);
        do_op("mul_9_9",   4'b1000, 6'd9,  6'd9,  1'b0, 0);
        do_op("bp_add",    4'b0010, 6'd20, 6'd22, 1'b1, 3);
        do_op("illegal",   4'b1111, 6'd12, 6'd34, 1'b1, 0);

        // Back-to-back single-cycle ops with out_ready held high
        tp_op[0] = 4'b0111; tp_a[0] = 6'b111101; tp_b[0] = 6'd2;  tp_c[0] = 1'b0;
        tp_op[1] = 4'b0000; tp_a[1] = 6'h33;     tp_b[1] = 6'h0F; tp_c[1] = 1'b0;
        tp_op[2] = 4'b1100; tp_a[2] = 6'h00;     tp_b[2] = 6'h00; tp_c[2] = 1'b0;
        for (int i = 3; i < 13; i++) begin
            tp_op[i] = sc_ops[$urandom_range(0, 7)];
            tp_a[i]  = W'($urandom);
            tp_b[i]  = W'($urandom);
            tp_c[i]  = 1'($urandom);
        end
        out_ready = 1'b1;
        in_valid = 1'b1; alu_op = tp_op[0]; a = tp_a[0]; b = tp_b[0]; carry_in = tp_c[0];
        #1;
        check("tp.in_ready0", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        for (int i = 1; i <= 13; i++) begin
            e = model(tp_op[i-1], tp_a[i-1], tp_b[i-1], tp_c[i-1]);
            check_out($sformatf("tp%0d", i - 1), e);
            $display("tp %0d alu_op=%b a=%0d b=%0d -> result=%0d", i - 1,
                     tp_op[i-1], tp_a[i-1], tp_b[i-1], result);
            if (i < 13) begin
                alu_op = tp_op[i]; a = tp_a[i]; b = tp_b[i]; carry_in = tp_c[i];
            end else begin
                in_valid = 1'b0;
            end
            check($sformatf("tp%0d.in_ready", i), 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        check("tp.drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Reset while a multiply (or, without it, a pending result) is in flight
        in_valid = 1'b1; alu_op = 4'b1000; a = 6'd7; b = 6'd9; carry_in = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle("rst_mid");
        w = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk); #1;
            if (out_valid) w++;
        end
        check("rst_mid.no_result", 32'(w), 32'd0);
        $display("reset mid-operation: out_valid cycles afterwards=%0d", w);

        // Random operations over all opcodes with random backpressure
        for (int i = 0; i < 40; i++) begin
            do_op($sformatf("rnd%0d", i), 4'($urandom), W'($urandom), W'($urandom),
                  1'($urandom), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_nbit.md
# alu_seq_nbit

Parametrised, registered N-bit ALU: successor to the hand-chained 1-bit ALU slices, with a valid/ready handshake, status flags and an optional multi-cycle shift-add multiply. Sits between operand-fetch and writeback. Accepts one operation at a time and holds its result until the consumer takes it.

## Interface
- WIDTH, 6: operand/result width, ≥2
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready at a clk edge
- a, b  in  WIDTH  operands
- carry_in  in  1  carry into bit 0 (ADD only)
- alu_op  in  4  opcode
- out_valid  out  1  result registers hold a result
- out_ready  in  1  consumer takes the result when out_valid && out_ready
- result  out  WIDTH  result
- carry_out, overflow, zero, negative, err  out  1 each  status flags

## Operation
- Opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD: a+b+carry_in
  - 0110 SUB: a+~b+1, carry_in ignored
  - 0111 SLT: signed; result = {0…,a<b}
  - 1100 NOR
  - 1000 MUL
- carry_out:
  - ADD/SUB: carry out of bit WIDTH-1; for SUB, 1 = no borrow
  - MUL: OR of the discarded upper product bits
  - all other ops: 0
- overflow: signed overflow for ADD/SUB only, else 0.
- zero = (result==0); negative = result[WIDTH-1]; both valid for every op.
- Any other opcode: result 0, err=1, remaining flags computed from result 0 (zero=1), single-cycle.
- FSM states:
  - IDLE: in_ready = !out_valid || out_ready.
  - MUL: in_ready=0.
  - Transitions:
    - IDLE→MUL on accepted MUL.
    - MUL→IDLE after the final iteration, loading the result.
  - Single-cycle ops stay in IDLE.
- MUL: unsigned shift-add, one multiplier bit per cycle; result = low WIDTH bits of a*b.
- Output registers load only on completion. They are unchanged while out_valid && !out_ready.
- Simultaneous output take and new accept in the same cycle is legal (full throughput for single-cycle ops).
- Operands are captured at accept. Input changes afterwards have no effect.

## Timing
- Reset: out_valid=0, result=0, all flags=0, state IDLE, in_ready=1 in the cycle after reset deasserts.
- Single-cycle op accepted at edge k → out_valid=1 and result valid after edge k, i.e. in cycle k+1.
- MUL accepted at edge k → out_valid rises after edge k+WIDTH. in_ready stays 0 through edge k+WIDTH.
- out_valid falls after the edge where out_ready=1, unless a new single-cycle op is accepted at that edge.
- Reset during MUL: the operation is aborted and no result is produced.
- Reset while out_valid=1: the pending result is dropped.
- in_valid while in_ready=0: ignored; no capture.

## Configuration
- ALU_MUL_EN defined: MUL opcode 1000 implemented as above, and the MUL state is present.
- ALU_MUL_EN undefined: 1000 is illegal (err=1, single-cycle, result 0). The FSM reduces to IDLE only and in_ready = !out_valid || out_ready.

## Structure
- Package alu_pkg holds:
  - opcode localparams: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL
  - state typedef: ST_IDLE, ST_MUL
- Sub-module alu_core_comb: combinational WIDTH-bit ALU producing result, carry_out and overflow for the single-cycle ops.
- The top holds the handshake, FSM, multiply datapath and output registers.

## Test plan
All scenarios at WIDTH=6.
- ADD a=19, b=15, carry_in=0 → result=34 (6'b100010), carry_out=0, overflow=1, negative=1, out_valid one cycle after accept.
- SUB a=5, b=7 → result=62, carry_out=0, zero=0. SUB a=9, b=9 → result=0, zero=1, carry_out=1.
- SLT a=6'b111101 (−3), b=2 → result=1. Then AND 6'h33 & 6'h0F → 6'h03. Then NOR 0,0 → 6'h3F, negative=1. Issued back-to-back with out_ready=1 → one result per cycle.
- MUL (ALU_MUL_EN) a=7, b=9 → result=63, carry_out=0, out_valid 6 cycles after accept. MUL a=9, b=9 → result=17, carry_out=1. Without ALU_MUL_EN the same stimulus → err=1, result=0, 1-cycle latency.
- Backpressure: ADD result pending with out_ready=0 for 3 cycles → result and flags stable, in_ready=0, new in_valid ignored. out_ready=1 → taken, and in_ready=1 in the same cycle.
- Illegal alu_op=4'b1111 → err=1, zero=1. Reset asserted mid-MUL → out_valid=0, flags=0, in_ready=1 after reset deasserts.
